// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: controller FSM states and ALU operand-source codes.
// Pure declarations; no logic or latency of its own.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, increments by one per cycle with inc=1, holds at all-ones.
// Output is registered; the increment never backpressures.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard/forward/flush controller with drain FSM and perf counters.
// Hazard, forward and flush outputs are combinational; drained and counters are registered.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int FWD_EN     = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  enable,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  ex_reg_write,
    input  logic                  mem_reg_write,
    input  logic                  wb_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  redirect,
    input  logic                  drain_req,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  drained,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_v_id, r_v_ex, r_v_mem, r_v_wb;
    logic   w_fetch_on, w_drained, w_drain_done;

    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
    logic w_load_use, w_any_raw, w_stall, w_redirect_q, w_advance;

    // A source only hazards when both ends are live instructions and rd is not x0.
    assign w_ex_a  = r_v_id & id_use_rs1 & r_v_ex  & ex_reg_write  & (ex_rd  != '0) & (ex_rd  == id_rs1);
    assign w_ex_b  = r_v_id & id_use_rs2 & r_v_ex  & ex_reg_write  & (ex_rd  != '0) & (ex_rd  == id_rs2);
    assign w_mem_a = r_v_id & id_use_rs1 & r_v_mem & mem_reg_write & (mem_rd != '0) & (mem_rd == id_rs1);
    assign w_mem_b = r_v_id & id_use_rs2 & r_v_mem & mem_reg_write & (mem_rd != '0) & (mem_rd == id_rs2);
    assign w_wb_a  = r_v_id & id_use_rs1 & r_v_wb  & wb_reg_write  & (wb_rd  != '0) & (wb_rd  == id_rs1);
    assign w_wb_b  = r_v_id & id_use_rs2 & r_v_wb  & wb_reg_write  & (wb_rd  != '0) & (wb_rd  == id_rs2);

    assign w_load_use   = ex_mem_read & (w_ex_a | w_ex_b);
    assign w_any_raw    = w_ex_a | w_ex_b | w_mem_a | w_mem_b | w_wb_a | w_wb_b;
    assign w_stall      = (FWD_EN != 0) ? w_load_use : w_any_raw;
    assign w_redirect_q = redirect & r_v_mem;
    assign w_advance    = w_redirect_q | ~w_stall;

    assign fwd_a = (FWD_EN != 0) ? fwd_sel(w_mem_a, w_wb_a) : FWD_RF;
    assign fwd_b = (FWD_EN != 0) ? fwd_sel(w_mem_b, w_wb_b) : FWD_RF;

    // Redirect outranks a stall: the stalled instruction is squashed anyway.
    assign pc_en        = enable & w_fetch_on & w_advance;
    assign if_id_en     = enable & w_advance;
    assign if_id_flush  = enable & w_redirect_q;
    assign id_ex_flush  = enable & (w_redirect_q | w_stall);
    assign ex_mem_flush = enable & w_redirect_q;
    assign drained      = w_drained;

    // With fetch off, nothing refills; ID and EX drain forward and MEM can't be squashed.
    assign w_drain_done = ~(r_v_id | r_v_ex | r_v_mem);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= RUN;
        end else if (enable) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch_on  = 1'b0;
        w_drained   = 1'b0;
        case (r_state)
            RUN: begin
                w_fetch_on = ~drain_req;
                if (drain_req) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_drain_done) w_state_nxt = HALT;
            end
            HALT: begin
                w_drained = 1'b1;
                if (!drain_req) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_v_id  <= 1'b0;
            r_v_ex  <= 1'b0;
            r_v_mem <= 1'b0;
            r_v_wb  <= 1'b0;
        end else if (enable) begin
            r_v_wb  <= r_v_mem;
            r_v_mem <= r_v_ex & ~w_redirect_q;
            r_v_ex  <= r_v_id & ~w_stall & ~w_redirect_q;
            r_v_id  <= w_redirect_q ? 1'b0 : (w_stall ? r_v_id : w_fetch_on);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (enable & w_stall & ~w_redirect_q),
        .cnt    (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (enable & w_redirect_q),
        .cnt    (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (enable & r_v_wb),
        .cnt    (retire_cnt)
    );

endmodule
